stopwatch_timebase: RTL

- Upstream time source for the FND display controller.
- Generates a 10 ms tick from the system clock and runs a cascaded msec/sec/min/hour counter chain under a run/stop/clear state machine.
- Drives the msec, sec, min and hour buses consumed by the display controller.
- Button inputs come from the board debouncers; this block synchronizes them and edge-detects them.

---
 rtl/stopwatch_timebase_if.sv | 27 ++
 rtl/stopwatch_timebase.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_timebase_if.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_timebase_if
// Description : Button inputs and time/status outputs of the stopwatch timebase.
// Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_timebase_if;
  logic       btn_run;
  logic       btn_clear;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       running;
  logic       tick;

  modport master (
    output btn_run, btn_clear,
    input  msec, sec, min, hour, running, tick
  );

  modport slave (
    input  btn_run, btn_clear,
    output msec, sec, min, hour, running, tick
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_timebase.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_timebase
// Description : 10 ms tick generator with msec/sec/min/hour cascade under a
//               run/stop/clear FSM, fed by synchronized, edge-detected buttons.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_timebase #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  stopwatch_timebase_if.slave   bus
);

  localparam int                  c_div      = CLK_FREQ / TICK_HZ;
  localparam int                  c_cnt_w    = $clog2(c_div);
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(c_div - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_running;
  logic                 r_run_meta, r_run_sync, r_run_prev;
  logic                 r_clr_meta, r_clr_sync, r_clr_prev;
  logic [2:0]           r_settle;
  logic                 w_run_edge, w_clr_edge;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_tick;
  logic [6:0]           r_msec;
  logic [5:0]           r_sec;
  logic [5:0]           r_min;
  logic [4:0]           r_hour;
  logic                 w_msec_wrap, w_sec_wrap, w_min_wrap;

  // Edges stay masked until prev holds a post-reset sample, so a button held
  // through reset is not mistaken for a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_meta <= 1'b0;
      r_run_sync <= 1'b0;
      r_run_prev <= 1'b0;
      r_clr_meta <= 1'b0;
      r_clr_sync <= 1'b0;
      r_clr_prev <= 1'b0;
      r_settle   <= 3'b000;
    end else begin
      r_run_meta <= bus.btn_run;
      r_run_sync <= r_run_meta;
      r_run_prev <= r_run_sync;
      r_clr_meta <= bus.btn_clear;
      r_clr_sync <= r_clr_meta;
      r_clr_prev <= r_clr_sync;
      r_settle   <= {r_settle[1:0], 1'b1};
    end
  end

  assign w_run_edge = r_run_sync & ~r_run_prev & r_settle[2];
  assign w_clr_edge = r_clr_sync & ~r_clr_prev & r_settle[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_STOP;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == ST_RUN);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_STOP: begin
        if (w_clr_edge)
          w_state_next = ST_CLEAR;
        else if (w_run_edge)
          w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_run_edge)
          w_state_next = ST_STOP;
      end
      ST_CLEAR: w_state_next = ST_STOP;
      default:  w_state_next = ST_STOP;
    endcase
  end

  assign w_tick = (r_state == ST_RUN) && (r_cnt == c_cnt_last);

  // Holding the count in STOP keeps the partial interval across pause/resume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (w_state_next == ST_CLEAR)
      r_cnt <= '0;
    else if (r_state == ST_RUN)
      r_cnt <= w_tick ? '0 : r_cnt + c_cnt_one;
  end

  assign w_msec_wrap = (r_msec == 7'd99);
  assign w_sec_wrap  = (r_sec  == 6'd59);
  assign w_min_wrap  = (r_min  == 6'd59);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msec <= 7'd0;
      r_sec  <= 6'd0;
      r_min  <= 6'd0;
      r_hour <= 5'd0;
    end else if (w_state_next == ST_CLEAR) begin
      r_msec <= 7'd0;
      r_sec  <= 6'd0;
      r_min  <= 6'd0;
      r_hour <= 5'd0;
    end else if (w_tick) begin
      if (w_msec_wrap) begin
        r_msec <= 7'd0;
        if (w_sec_wrap) begin
          r_sec <= 6'd0;
          if (w_min_wrap) begin
            r_min  <= 6'd0;
            r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
          end else begin
            r_min <= r_min + 6'd1;
          end
        end else begin
          r_sec <= r_sec + 6'd1;
        end
      end else begin
        r_msec <= r_msec + 7'd1;
      end
    end
  end

  assign bus.msec    = r_msec;
  assign bus.sec     = r_sec;
  assign bus.min     = r_min;
  assign bus.hour    = r_hour;
  assign bus.running = r_running;
  assign bus.tick    = w_tick;

endmodule
`default_nettype wire
